// File: rtl/rs_age_queue.sv
// Reservation station: dispatch capture, CDB wakeup, locked valid/ready issue, free on accept.
// Define RS_AGE_ISSUE_EN to pick the oldest eligible entry via an age matrix; else lowest index wins.
module rs_age_queue #(
    parameter int NUM_ENTRIES = 8,
    parameter int NUM_CDB     = 2,
    parameter int TAG_W       = 5,
    parameter int XLEN        = 32,
    parameter int PAYLOAD_W   = 64
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          flush,
    input  logic                          dp_valid,
    output logic                          dp_ready,
    input  logic [TAG_W-1:0]              dp_tag,
    input  logic                          dp_src1_rdy,
    input  logic                          dp_src2_rdy,
    input  logic [TAG_W-1:0]              dp_src1_tag,
    input  logic [TAG_W-1:0]              dp_src2_tag,
    input  logic [XLEN-1:0]               dp_src1_val,
    input  logic [XLEN-1:0]               dp_src2_val,
    input  logic [PAYLOAD_W-1:0]          dp_payload,
    input  logic [NUM_CDB-1:0]            cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]      cdb_tag,
    input  logic [NUM_CDB*XLEN-1:0]       cdb_value,
    output logic                          is_valid,
    input  logic                          is_ready,
    output logic [TAG_W-1:0]              is_tag,
    output logic [XLEN-1:0]               is_src1_val,
    output logic [XLEN-1:0]               is_src2_val,
    output logic [PAYLOAD_W-1:0]          is_payload,
    output logic [$clog2(NUM_ENTRIES):0]  occupancy
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int OCC_W = IDX_W + 1;

    logic [NUM_ENTRIES-1:0] busy_r;
    logic [NUM_ENTRIES-1:0] src1_rdy_r;
    logic [NUM_ENTRIES-1:0] src2_rdy_r;
    logic [TAG_W-1:0]       tag_r      [NUM_ENTRIES];
    logic [TAG_W-1:0]       src1_tag_r [NUM_ENTRIES];
    logic [TAG_W-1:0]       src2_tag_r [NUM_ENTRIES];
    logic [XLEN-1:0]        src1_val_r [NUM_ENTRIES];
    logic [XLEN-1:0]        src2_val_r [NUM_ENTRIES];
    logic [PAYLOAD_W-1:0]   payload_r  [NUM_ENTRIES];
    logic                   lock_vld_r;
    logic [IDX_W-1:0]       lock_idx_r;
    logic                   dp_ready_r;
    logic [OCC_W-1:0]       occ_r;

    logic [XLEN:0]          wk1_s [NUM_ENTRIES];
    logic [XLEN:0]          wk2_s [NUM_ENTRIES];
    logic [XLEN:0]          dp1_s;
    logic [XLEN:0]          dp2_s;
    logic [NUM_ENTRIES-1:0] eligible_s;
    logic [NUM_ENTRIES-1:0] busy_next_s;
    logic                   pick_vld_s;
    logic [IDX_W-1:0]       pick_idx_s;
    logic [IDX_W-1:0]       sel_idx_s;
    logic [IDX_W-1:0]       alloc_idx_s;
    logic                   is_valid_s;
    logic                   hs_s;
    logic                   fire_s;

    // Returns {hit, value}; the descending scan lets the lowest matching port win.
    function automatic logic [XLEN:0] cdb_lookup(
        input logic [TAG_W-1:0]         t,
        input logic [NUM_CDB-1:0]       v,
        input logic [NUM_CDB*TAG_W-1:0] tags,
        input logic [NUM_CDB*XLEN-1:0]  vals
    );
        logic [XLEN:0] r;
        r = '0;
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (v[k] && (tags[k*TAG_W +: TAG_W] == t)) begin
                r = {1'b1, vals[k*XLEN +: XLEN]};
            end
        end
        return r;
    endfunction

    function automatic logic [OCC_W-1:0] popcount(input logic [NUM_ENTRIES-1:0] v);
        logic [OCC_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            c = c + {{(OCC_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    assign eligible_s = busy_r & src1_rdy_r & src2_rdy_r;
    assign fire_s     = dp_valid & dp_ready_r & ~flush;

    // CDB lookups for resident sources and for the incoming dispatch
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            wk1_s[i] = cdb_lookup(src1_tag_r[i], cdb_valid, cdb_tag, cdb_value);
            wk2_s[i] = cdb_lookup(src2_tag_r[i], cdb_valid, cdb_tag, cdb_value);
        end
        dp1_s = cdb_lookup(dp_src1_tag, cdb_valid, cdb_tag, cdb_value);
        dp2_s = cdb_lookup(dp_src2_tag, cdb_valid, cdb_tag, cdb_value);
    end

`ifdef RS_AGE_ISSUE_EN
    logic [NUM_ENTRIES-1:0] older_r [NUM_ENTRIES];

    // Age matrix: older_r[i][j] set means entry j was dispatched before entry i
    always_ff @(posedge clock) begin
        if (!reset_n || flush) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                older_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                for (int j = 0; j < NUM_ENTRIES; j++) begin
                    if (fire_s && (alloc_idx_s == IDX_W'(i))) begin
                        older_r[i][j] <= busy_r[j] & ~(hs_s && (sel_idx_s == IDX_W'(j)));
                    end else if (hs_s && ((sel_idx_s == IDX_W'(i)) || (sel_idx_s == IDX_W'(j)))) begin
                        older_r[i][j] <= 1'b0;
                    end
                end
            end
        end
    end
`endif

    // Candidate selection among eligible entries
    always_comb begin
        pick_vld_s = 1'b0;
        pick_idx_s = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
`ifdef RS_AGE_ISSUE_EN
            if (eligible_s[i] && ((older_r[i] & eligible_s) == '0)) begin
`else
            if (eligible_s[i]) begin
`endif
                pick_vld_s = 1'b1;
                pick_idx_s = IDX_W'(i);
            end else begin
                pick_vld_s = pick_vld_s;
            end
        end
    end

    // Lowest-index free slot, judged on start-of-cycle occupancy
    always_comb begin
        alloc_idx_s = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!busy_r[i]) begin
                alloc_idx_s = IDX_W'(i);
            end else begin
                alloc_idx_s = alloc_idx_s;
            end
        end
    end

    assign sel_idx_s  = lock_vld_r ? lock_idx_r : pick_idx_s;
    assign is_valid_s = lock_vld_r | pick_vld_s;
    assign hs_s       = is_valid_s & is_ready;

    // Next busy vector; flush overrides issue and dispatch
    always_comb begin
        busy_next_s = busy_r;
        if (flush) begin
            busy_next_s = '0;
        end else begin
            if (hs_s) begin
                busy_next_s[sel_idx_s] = 1'b0;
            end else begin
                busy_next_s = busy_next_s;
            end
            if (fire_s) begin
                busy_next_s[alloc_idx_s] = 1'b1;
            end else begin
                busy_next_s = busy_next_s;
            end
        end
    end

    // Busy vector, occupancy, dispatch ready and issue lock
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            busy_r     <= '0;
            dp_ready_r <= 1'b1;
            occ_r      <= '0;
            lock_vld_r <= 1'b0;
            lock_idx_r <= '0;
        end else begin
            busy_r     <= busy_next_s;
            dp_ready_r <= ~(&busy_next_s);
            occ_r      <= popcount(busy_next_s);
            if (flush || hs_s) begin
                lock_vld_r <= 1'b0;
            end else if (is_valid_s) begin
                lock_vld_r <= 1'b1;
                lock_idx_r <= sel_idx_s;
            end
        end
    end

    // Entry capture at dispatch (with same-cycle CDB bypass) and resident wakeup
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            src1_rdy_r <= '0;
            src2_rdy_r <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                tag_r[i]      <= '0;
                src1_tag_r[i] <= '0;
                src2_tag_r[i] <= '0;
                src1_val_r[i] <= '0;
                src2_val_r[i] <= '0;
                payload_r[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (fire_s && (alloc_idx_s == IDX_W'(i))) begin
                    tag_r[i]      <= dp_tag;
                    payload_r[i]  <= dp_payload;
                    src1_tag_r[i] <= dp_src1_tag;
                    src2_tag_r[i] <= dp_src2_tag;
                    src1_rdy_r[i] <= dp_src1_rdy | dp1_s[XLEN];
                    src2_rdy_r[i] <= dp_src2_rdy | dp2_s[XLEN];
                    src1_val_r[i] <= dp_src1_rdy ? dp_src1_val : dp1_s[XLEN-1:0];
                    src2_val_r[i] <= dp_src2_rdy ? dp_src2_val : dp2_s[XLEN-1:0];
                end else if (busy_r[i]) begin
                    if (!src1_rdy_r[i] && wk1_s[i][XLEN]) begin
                        src1_rdy_r[i] <= 1'b1;
                        src1_val_r[i] <= wk1_s[i][XLEN-1:0];
                    end
                    if (!src2_rdy_r[i] && wk2_s[i][XLEN]) begin
                        src2_rdy_r[i] <= 1'b1;
                        src2_val_r[i] <= wk2_s[i][XLEN-1:0];
                    end
                end
            end
        end
    end

    assign is_valid    = is_valid_s;
    assign is_tag      = tag_r[sel_idx_s];
    assign is_src1_val = src1_val_r[sel_idx_s];
    assign is_src2_val = src2_val_r[sel_idx_s];
    assign is_payload  = payload_r[sel_idx_s];
    assign dp_ready    = dp_ready_r;
    assign occupancy   = occ_r;

endmodule

// File: tb/tb_rs_age_queue.sv
// Directed bench for rs_age_queue: vector table plus hand-written reset and issue-order sequences.
module tb_rs_age_queue;

`ifdef RS_AGE_ISSUE_EN
    localparam bit AGE = 1'b1;
`else
    localparam bit AGE = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        dp_valid;
    logic        dp_ready;
    logic [4:0]  dp_tag;
    logic        dp_src1_rdy, dp_src2_rdy;
    logic [4:0]  dp_src1_tag, dp_src2_tag;
    logic [31:0] dp_src1_val, dp_src2_val;
    logic [63:0] dp_payload;
    logic [1:0]  cdb_valid;
    logic [9:0]  cdb_tag;
    logic [63:0] cdb_value;
    logic        is_valid;
    logic        is_ready;
    logic [4:0]  is_tag;
    logic [31:0] is_src1_val, is_src2_val;
    logic [63:0] is_payload;
    logic [3:0]  occupancy;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    rs_age_queue dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .dp_valid(dp_valid), .dp_ready(dp_ready), .dp_tag(dp_tag),
        .dp_src1_rdy(dp_src1_rdy), .dp_src2_rdy(dp_src2_rdy),
        .dp_src1_tag(dp_src1_tag), .dp_src2_tag(dp_src2_tag),
        .dp_src1_val(dp_src1_val), .dp_src2_val(dp_src2_val),
        .dp_payload(dp_payload),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .is_valid(is_valid), .is_ready(is_ready), .is_tag(is_tag),
        .is_src1_val(is_src1_val), .is_src2_val(is_src2_val),
        .is_payload(is_payload), .occupancy(occupancy)
    );

    typedef struct {
        string       name;
        logic        dv;
        logic [4:0]  dtag;
        logic        r1;
        logic [4:0]  t1;
        logic [31:0] v1;
        logic        r2;
        logic [4:0]  t2;
        logic [31:0] v2;
        logic [1:0]  cv;
        logic [4:0]  ct0;
        logic [31:0] cd0;
        logic [4:0]  ct1;
        logic [31:0] cd1;
        logic        rdy;
        logic        fl;
        logic        e_valid;
        logic [4:0]  e_tag;
        logic [31:0] e_v1;
        logic [31:0] e_v2;
        logic        e_dprdy;
        logic [3:0]  e_occ;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [63:0] pl(input logic [4:0] t);
        return 64'hA5A5_0000_0000_0000 | {59'd0, t};
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic add(input string nm, input logic dv, input logic [4:0] dtag,
                       input logic r1, input logic [4:0] t1, input logic [31:0] v1,
                       input logic r2, input logic [4:0] t2, input logic [31:0] v2,
                       input logic [1:0] cv, input logic [4:0] ct0, input logic [31:0] cd0,
                       input logic [4:0] ct1, input logic [31:0] cd1,
                       input logic rdy, input logic fl,
                       input logic ev, input logic [4:0] etag, input logic [31:0] ev1,
                       input logic [31:0] ev2, input logic edp, input logic [3:0] eocc);
        vec_t v;
        v.name = nm; v.dv = dv; v.dtag = dtag;
        v.r1 = r1; v.t1 = t1; v.v1 = v1; v.r2 = r2; v.t2 = t2; v.v2 = v2;
        v.cv = cv; v.ct0 = ct0; v.cd0 = cd0; v.ct1 = ct1; v.cd1 = cd1;
        v.rdy = rdy; v.fl = fl;
        v.e_valid = ev; v.e_tag = etag; v.e_v1 = ev1; v.e_v2 = ev2;
        v.e_dprdy = edp; v.e_occ = eocc;
        tbl.push_back(v);
    endtask

    task automatic idle();
        flush = 1'b0; dp_valid = 1'b0; dp_tag = 5'd0;
        dp_src1_rdy = 1'b0; dp_src2_rdy = 1'b0;
        dp_src1_tag = 5'd0; dp_src2_tag = 5'd0;
        dp_src1_val = 32'd0; dp_src2_val = 32'd0; dp_payload = 64'd0;
        cdb_valid = 2'b00; cdb_tag = 10'd0; cdb_value = 64'd0;
        is_ready = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply(input vec_t v);
        flush = v.fl; dp_valid = v.dv; dp_tag = v.dtag; dp_payload = pl(v.dtag);
        dp_src1_rdy = v.r1; dp_src1_tag = v.t1; dp_src1_val = v.v1;
        dp_src2_rdy = v.r2; dp_src2_tag = v.t2; dp_src2_val = v.v2;
        cdb_valid = v.cv; cdb_tag = {v.ct1, v.ct0}; cdb_value = {v.cd1, v.cd0};
        is_ready = v.rdy;
        tick();
        chk({v.name, ".is_valid"}, 64'(is_valid), 64'(v.e_valid));
        chk({v.name, ".dp_ready"}, 64'(dp_ready), 64'(v.e_dprdy));
        chk({v.name, ".occupancy"}, 64'(occupancy), 64'(v.e_occ));
        if (v.e_valid) begin
            chk({v.name, ".is_tag"}, 64'(is_tag), 64'(v.e_tag));
            chk({v.name, ".is_src1_val"}, 64'(is_src1_val), 64'(v.e_v1));
            chk({v.name, ".is_src2_val"}, 64'(is_src2_val), 64'(v.e_v2));
            chk({v.name, ".is_payload"}, is_payload, pl(v.e_tag));
        end
    endtask

    initial begin
        logic [4:0] first_t;
        logic [4:0] second_t;

        // Basic dispatch/issue, resident wakeup, dispatch bypass, port priority
        //   name             dv dtag  r1 t1     v1        r2 t2     v2        cv     ct0    cd0        ct1    cd1        rdy fl   ev tag   ev1       ev2       dp occ
        add("disp_t3",        1, 5'd3, 1, 5'd0,  32'h10,   1, 5'd0,  32'h20,   2'b00, 5'd0,  32'h0,     5'd0,  32'h0,     1,  0,   1, 5'd3, 32'h10,   32'h20,   1, 4'd1);
        add("issue_t3",       0, 5'd0, 0, 5'd0,  32'h0,    0, 5'd0,  32'h0,    2'b00, 5'd0,  32'h0,     5'd0,  32'h0,     1,  0,   0, 5'd0, 32'h0,    32'h0,    1, 4'd0);
        add("disp_t4_wait9",  1, 5'd4, 0, 5'd9,  32'h0,    1, 5'd0,  32'h22,   2'b00, 5'd0,  32'h0,     5'd0,  32'h0,     1,  0,   0, 5'd0, 32'h0,    32'h0,    1, 4'd1);
        add("cdb0_t9",        0, 5'd0, 0, 5'd0,  32'h0,    0, 5'd0,  32'h0,    2'b01, 5'd9,  32'hAB,    5'd0,  32'h0,     1,  0,   1, 5'd4, 32'hAB,   32'h22,   1, 4'd1);
        add("issue_t4",       0, 5'd0, 0, 5'd0,  32'h0,    0, 5'd0,  32'h0,    2'b00, 5'd0,  32'h0,     5'd0,  32'h0,     1,  0,   0, 5'd0, 32'h0,    32'h0,    1, 4'd0);
        add("disp_t5_bypass", 1, 5'd5, 0, 5'd7,  32'h0,    1, 5'd0,  32'h66,   2'b10, 5'd7,  32'hDEAD,  5'd7,  32'h55,    0,  0,   1, 5'd5, 32'h55,   32'h66,   1, 4'd1);
        add("issue_t5",       0, 5'd0, 0, 5'd0,  32'h0,    0, 5'd0,  32'h0,    2'b00, 5'd0,  32'h0,     5'd0,  32'h0,     1,  0,   0, 5'd0, 32'h0,    32'h0,    1, 4'd0);
        add("disp_t6_wait",   1, 5'd6, 0, 5'd12, 32'h0,    0, 5'd13, 32'h0,    2'b00, 5'd0,  32'h0,     5'd0,  32'h0,     1,  0,   0, 5'd0, 32'h0,    32'h0,    1, 4'd1);
        add("cdb_both_t12",   0, 5'd0, 0, 5'd0,  32'h0,    0, 5'd0,  32'h0,    2'b11, 5'd12, 32'h111,   5'd12, 32'h222,   1,  0,   0, 5'd0, 32'h0,    32'h0,    1, 4'd1);
        add("cdb1_t13",       0, 5'd0, 0, 5'd0,  32'h0,    0, 5'd0,  32'h0,    2'b10, 5'd0,  32'h0,     5'd13, 32'h333,   0,  0,   1, 5'd6, 32'h111,  32'h333,  1, 4'd1);
        add("issue_t6",       0, 5'd0, 0, 5'd0,  32'h0,    0, 5'd0,  32'h0,    2'b00, 5'd0,  32'h0,     5'd0,  32'h0,     1,  0,   0, 5'd0, 32'h0,    32'h0,    1, 4'd0);
        // Fill with EX stalled; oldest (slot 0, tag 10) stays on the issue port
        for (int k = 0; k < 8; k++) begin
            add($sformatf("fill%0d", k), 1, 5'(10 + k), 1, 5'd0, 32'(10 + k), 1, 5'd0, 32'(266 + k),
                2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 0, 0,
                1, 5'd10, 32'd10, 32'd266, (k < 7), 4'(k + 1));
        end
        add("full_ignored",   1, 5'd30, 1, 5'd0, 32'h30,   1, 5'd0,  32'h31,   2'b00, 5'd0,  32'h0,     5'd0,  32'h0,     0,  0,   1, 5'd10, 32'd10,  32'd266,  0, 4'd8);
        add("hs_from_full",   0, 5'd0, 0, 5'd0,  32'h0,    0, 5'd0,  32'h0,    2'b00, 5'd0,  32'h0,     5'd0,  32'h0,     1,  0,   1, 5'd11, 32'd11,  32'd267,  1, 4'd7);
        add("issue_and_disp", 1, 5'd20, 1, 5'd0, 32'h20,   1, 5'd0,  32'h21,   2'b00, 5'd0,  32'h0,     5'd0,  32'h0,     1,  0,
            1, AGE ? 5'd12 : 5'd20, AGE ? 32'd12 : 32'h20, AGE ? 32'd268 : 32'h21, 1, 4'd7);
        add("flush_with_disp",1, 5'd21, 1, 5'd0, 32'h1,    1, 5'd0,  32'h2,    2'b00, 5'd0,  32'h0,     5'd0,  32'h0,     1,  1,   0, 5'd0, 32'h0,    32'h0,    1, 4'd0);
        // Lock: an older entry waking while stalled must not disturb the issue port
        add("lock_disp_t1",   1, 5'd1, 0, 5'd25, 32'h0,    1, 5'd0,  32'h2,    2'b00, 5'd0,  32'h0,     5'd0,  32'h0,     0,  0,   0, 5'd0, 32'h0,    32'h0,    1, 4'd1);
        add("lock_disp_t2",   1, 5'd2, 1, 5'd0,  32'h3,    1, 5'd0,  32'h4,    2'b00, 5'd0,  32'h0,     5'd0,  32'h0,     0,  0,   1, 5'd2, 32'h3,    32'h4,    1, 4'd2);
        add("lock_wake_old",  0, 5'd0, 0, 5'd0,  32'h0,    0, 5'd0,  32'h0,    2'b01, 5'd25, 32'h99,    5'd0,  32'h0,     0,  0,   1, 5'd2, 32'h3,    32'h4,    1, 4'd2);
        add("lock_release",   0, 5'd0, 0, 5'd0,  32'h0,    0, 5'd0,  32'h0,    2'b00, 5'd0,  32'h0,     5'd0,  32'h0,     1,  0,   1, 5'd1, 32'h99,   32'h2,    1, 4'd1);
        add("lock_drain",     0, 5'd0, 0, 5'd0,  32'h0,    0, 5'd0,  32'h0,    2'b00, 5'd0,  32'h0,     5'd0,  32'h0,     1,  0,   0, 5'd0, 32'h0,    32'h0,    1, 4'd0);

        // Reset state
        idle();
        reset_n = 1'b0;
        dp_valid = 1'b1;
        dp_src1_rdy = 1'b1;
        dp_src2_rdy = 1'b1;
        tick();
        tick();
        chk("reset.is_valid", 64'(is_valid), 64'd0);
        chk("reset.dp_ready", 64'(dp_ready), 64'd1);
        chk("reset.occupancy", 64'(occupancy), 64'd0);
        idle();
        reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
        end

        // Issue order after slot reuse: B sits in slot 1, younger C reuses slot 0
        first_t  = AGE ? 5'd27 : 5'd28;
        second_t = AGE ? 5'd28 : 5'd27;
        idle();
        dp_valid = 1'b1; dp_tag = 5'd26; dp_payload = pl(5'd26);
        dp_src1_rdy = 1'b1; dp_src1_val = 32'h26; dp_src2_rdy = 1'b1; dp_src2_val = 32'h27;
        tick();
        chk("age_a.is_valid", 64'(is_valid), 64'd1);
        chk("age_a.is_tag", 64'(is_tag), 64'd26);
        idle();
        dp_valid = 1'b1; dp_tag = 5'd27; dp_payload = pl(5'd27);
        dp_src1_tag = 5'd31; dp_src2_rdy = 1'b1; dp_src2_val = 32'h5;
        is_ready = 1'b1;
        tick();
        chk("age_b.is_valid", 64'(is_valid), 64'd0);
        chk("age_b.occupancy", 64'(occupancy), 64'd1);
        idle();
        dp_valid = 1'b1; dp_tag = 5'd28; dp_payload = pl(5'd28);
        dp_src1_tag = 5'd31; dp_src2_rdy = 1'b1; dp_src2_val = 32'h6;
        tick();
        chk("age_c.occupancy", 64'(occupancy), 64'd2);
        idle();
        cdb_valid = 2'b10; cdb_tag = {5'd31, 5'd0}; cdb_value = {32'h77, 32'h0};
        tick();
        chk("age_first.is_valid", 64'(is_valid), 64'd1);
        chk("age_first.is_tag", 64'(is_tag), 64'(first_t));
        chk("age_first.is_src1_val", 64'(is_src1_val), 64'h77);
        chk("age_first.is_src2_val", 64'(is_src2_val), AGE ? 64'h5 : 64'h6);
        idle();
        is_ready = 1'b1;
        tick();
        chk("age_second.is_valid", 64'(is_valid), 64'd1);
        chk("age_second.is_tag", 64'(is_tag), 64'(second_t));
        chk("age_second.is_payload", is_payload, pl(second_t));
        idle();
        is_ready = 1'b1;
        tick();
        chk("age_empty.is_valid", 64'(is_valid), 64'd0);
        chk("age_empty.occupancy", 64'(occupancy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rs_age_queue.md
# rs_age_queue

Parametrised reservation station: a configurable number of entries and CDB ports, with oldest-first issue and a valid/ready issue handshake. It sits between dispatch and a single execution unit. It captures operands from dispatch or from the CDBs, wakes entries on tag match, and issues one ready entry per cycle. An entry is freed when its issue is accepted, not when it completes.

## Interface
Parameters:
- NUM_ENTRIES, 8: entry count, power of two, ≥2.
- NUM_CDB, 2: number of CDB broadcast ports.
- TAG_W, 5: ROB tag width.
- XLEN, 32: operand width.
- PAYLOAD_W, 64: opaque decoded-instruction payload carried to EX.

Ports:
- clock, input, 1: single clock; all state updates on the rising edge.
- reset_n, input, 1: reset is synchronous and active-low.
- flush, input, 1: squash all entries (branch mispredict).
- dp_valid, input, 1: dispatch request.
- dp_ready, output, 1: at least one free entry (registered state).
- dp_tag, input, TAG_W: destination ROB tag.
- dp_src1_rdy / dp_src2_rdy, input, 1 each: operand value already valid.
- dp_src1_tag / dp_src2_tag, input, TAG_W: producer tag when not ready.
- dp_src1_val / dp_src2_val, input, XLEN: operand value when ready.
- dp_payload, input, PAYLOAD_W: carried unchanged to issue.
- cdb_valid, input, NUM_CDB: per-port broadcast valid.
- cdb_tag, input, NUM_CDB*TAG_W: port k at bits [k*TAG_W +: TAG_W].
- cdb_value, input, NUM_CDB*XLEN: port k at bits [k*XLEN +: XLEN].
- is_valid, output, 1: issue request.
- is_ready, input, 1: EX accepts.
- is_tag, output, TAG_W: issued entry fields.
- is_src1_val / is_src2_val, output, XLEN: issued entry fields.
- is_payload, output, PAYLOAD_W: issued entry fields.
- occupancy, output, $clog2(NUM_ENTRIES)+1: number of busy entries.

## Operation
- Entry state: busy, tag, src{1,2}_{rdy,tag,val}, payload, age information.
- Dispatch fires when dp_valid && dp_ready.
  - Writes the lowest-index free entry.
  - Each not-ready source whose tag matches any valid CDB port in the same cycle is written as ready with that CDB value (dispatch-cycle bypass).
- Wakeup: each busy entry, each not-ready source, compares against all CDB ports. On a match the source captures the value and becomes ready.
  - Multiple matching ports: the lowest port index wins.
- An entry is eligible when busy && src1_rdy && src2_rdy.
- Selection:
  - Oldest eligible entry (see Configuration).
  - When is_valid is high and is_ready is low, the selection is locked to that entry until the handshake. Outputs are stable while locked, even if an older entry becomes eligible.
- Issue handshake: is_valid && is_ready → entry busy cleared and lock released.
- Outputs is_* are combinational from registered entry state. is_* data are don't-care when is_valid=0.
- Flush:
  - Clears every busy bit and the lock.
  - Has priority over same-cycle dispatch, wakeup and handshake.
  - dp_ready is still computed from pre-flush state, but the dispatch is dropped.
- Issue and dispatch in the same cycle:
  - The slot freed by the issue is not reusable until the next cycle.
  - Dispatch picks among slots free at the start of the cycle.
- occupancy = popcount(busy), updated the cycle after dispatch, issue or flush.
- Reset values (reset_n=0 at an edge):
  - all busy=0, lock cleared.
  - is_valid=0, dp_ready=1, occupancy=0.
  - Age state zeroed.

## Timing
- Dispatch with both sources ready at edge N → is_valid in cycle N+1.
- CDB match at edge N (dispatch-time or resident) → entry eligible in cycle N+1.
- Handshake at edge N → entry free from N+1; occupancy drops at N+1.
- Full: dp_ready=0 whenever occupancy==NUM_ENTRIES. A dp_valid asserted while full is ignored; no state changes.
- Empty: is_valid=0.
- Throughput: one dispatch and one issue per cycle.

## Configuration
- RS_AGE_ISSUE_EN defined:
  - An NUM_ENTRIES×NUM_ENTRIES age matrix is maintained.
  - On dispatch, the new entry's row marks all currently busy entries as older.
  - On issue or flush, the matching row and column are cleared.
  - Selection picks the eligible entry with no older eligible entry.
- RS_AGE_ISSUE_EN undefined:
  - No age matrix.
  - Selection picks the lowest-index eligible entry.
  - Lock and handshake rules are unchanged.

## Test plan
- Reset, then dispatch tag 3 with src1=0x10 and src2=0x20 ready, is_ready=1 → is_valid at N+1 with is_tag=3, values 0x10/0x20; occupancy 1→0.
- Dispatch tag 4 with src1 waiting on tag 9, then broadcast CDB0 tag 9 value 0xAB → is_valid the cycle after the broadcast with is_src1_val=0xAB.
- Dispatch tag 5 waiting on tag 7 in the same cycle as a CDB1 broadcast of tag 7 value 0x55 → captured; issues next cycle with 0x55.
- Fill 8 entries with is_ready=0 → dp_ready=0 and occupancy=8. A 9th dp_valid is ignored. One handshake → dp_ready=1 the following cycle.
- RS_AGE_ISSUE_EN: dispatch A into slot 0 and B into slot 1, free slot 0, dispatch C into slot 0, make all ready → issue order B, C. Without the macro the order is C, B.
- With is_valid held and is_ready=0, an older entry wakes → outputs unchanged. A flush in the same cycle as a dispatch → occupancy=0 and is_valid=0 next cycle.
